// File: rtl/gesture_vote_if.sv
// Purpose: label-in / vote-out bundle between frame detection and the gesture voter.
// Ports  : clear, in_valid, in_class -> voter; in_ready, result, result_conf,
//          others_cnt, result_valid, no_decision -> consumer.
interface gesture_vote_if #(
  parameter int CLASS_W = 4,
  parameter int CNT_W   = 4
);
  logic               clear;
  logic               in_valid;
  logic [CLASS_W-1:0] in_class;
  logic               in_ready;
  logic [CLASS_W-1:0] result;
  logic [CNT_W-1:0]   result_conf;
  logic [CNT_W-1:0]   others_cnt;
  logic               result_valid;
  logic               no_decision;

  // Upstream side: frame detector plus result consumer.
  modport master (
    output clear, in_valid, in_class,
    input  in_ready, result, result_conf, others_cnt, result_valid, no_decision
  );

  // Voter side.
  modport slave (
    input  clear, in_valid, in_class,
    output in_ready, result, result_conf, others_cnt, result_valid, no_decision
  );
endinterface

// File: rtl/gesture_vote.sv
// Purpose     : bins WINDOW frame labels, then scans NUM_CLASSES bins to vote a winner
//               (MODE 0 highest non-empty class, MODE 1 most frequent, ties -> higher).
// Latency     : strobe visible NUM_CLASSES+2 cycles after the cycle of the WINDOW-th accept.
// Backpressure: in_ready low during SCAN/EMIT (NUM_CLASSES+1 cycles); labels offered then are dropped.
// Ports       : clk, rst_n (sync, active low); bus.slave carries clear, the label handshake
//               and the result/result_conf/others_cnt outputs with result_valid/no_decision strobes.
module gesture_vote #(
  parameter int CLASS_W     = 4,
  parameter int NUM_CLASSES = 6,
  parameter int WINDOW      = 10,
  parameter int CNT_W       = $clog2(WINDOW + 1),
  parameter int MODE        = 0,
  parameter int MIN_VOTES   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  gesture_vote_if.slave bus
);

  typedef enum logic [1:0] {S_ACCUM, S_SCAN, S_EMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bin [NUM_CLASSES];
  logic [CNT_W-1:0]   r_others;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CLASS_W-1:0] r_idx;
  logic [CLASS_W-1:0] r_win;
  logic [CNT_W-1:0]   r_best;
  logic [CLASS_W-1:0] r_result;
  logic [CNT_W-1:0]   r_result_conf;
  logic [CNT_W-1:0]   r_others_cnt;
  logic               r_result_valid;
  logic               r_no_decision;

  logic               w_accept;
  logic               w_last;
  logic               w_is_other;
  logic [CNT_W-1:0]   w_bin_sel;
  logic               w_take;

  assign bus.in_ready     = (r_state == S_ACCUM);
  assign bus.result       = r_result;
  assign bus.result_conf  = r_result_conf;
  assign bus.others_cnt   = r_others_cnt;
  assign bus.result_valid = r_result_valid;
  assign bus.no_decision  = r_no_decision;

  // A label offered together with clear is discarded.
  assign w_accept   = bus.in_valid & bus.in_ready & ~bus.clear;
  assign w_last     = (r_frame_cnt == CNT_W'(WINDOW - 1));
  // Compare at 32 bits so NUM_CLASSES == 2**CLASS_W does not wrap to 0.
  assign w_is_other = (32'(bus.in_class) >= NUM_CLASSES);

  // Mux the bin under the scan index.
  always_comb begin
    w_bin_sel = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (r_idx == CLASS_W'(k)) w_bin_sel = r_bin[k];
    end
  end

  // MODE 0 latches the first non-empty bin seen from the top (best is still 0 until then);
  // MODE 1 only replaces on a strict increase so equal counts keep the higher class.
  always_comb begin
    w_take = 1'b0;
    if (MODE == 0) w_take = (r_best == '0) && (w_bin_sel != '0);
    else           w_take = (w_bin_sel > r_best);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM: if (w_accept && w_last) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_idx == '0)        w_state_nxt = S_EMIT;
      S_EMIT:                          w_state_nxt = S_ACCUM;
      default:                         w_state_nxt = S_ACCUM;
    endcase
    if (bus.clear) w_state_nxt = S_ACCUM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) r_bin[k] <= '0;
      r_others       <= '0;
      r_frame_cnt    <= '0;
      r_idx          <= '0;
      r_win          <= '0;
      r_best         <= '0;
      r_result       <= '0;
      r_result_conf  <= '0;
      r_others_cnt   <= '0;
      r_result_valid <= 1'b0;
      r_no_decision  <= 1'b0;
    end else if (bus.clear) begin
      // Abort the window; published outputs hold.
      for (int k = 0; k < NUM_CLASSES; k++) r_bin[k] <= '0;
      r_others       <= '0;
      r_frame_cnt    <= '0;
      r_idx          <= '0;
      r_win          <= '0;
      r_best         <= '0;
      r_result_valid <= 1'b0;
      r_no_decision  <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_no_decision  <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (w_is_other) r_others <= r_others + CNT_W'(1);
            for (int k = 0; k < NUM_CLASSES; k++) begin
              if (bus.in_class == CLASS_W'(k)) r_bin[k] <= r_bin[k] + CNT_W'(1);
            end
            if (w_last) begin
              r_idx  <= CLASS_W'(NUM_CLASSES - 1);
              r_win  <= '0;
              r_best <= '0;
            end
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_win  <= r_idx;
            r_best <= w_bin_sel;
          end
          if (r_idx != '0) r_idx <= r_idx - CLASS_W'(1);
        end
        S_EMIT: begin
          if (r_best >= CNT_W'(MIN_VOTES)) begin
            r_result       <= r_win;
            r_result_conf  <= r_best;
            r_result_valid <= 1'b1;
          end else begin
            r_no_decision  <= 1'b1;
          end
          r_others_cnt <= r_others;
          for (int k = 0; k < NUM_CLASSES; k++) r_bin[k] <= '0;
          r_others    <= '0;
          r_frame_cnt <= '0;
          r_idx       <= '0;
          r_win       <= '0;
          r_best      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
